// File: rtl/chacha20_keystream_xor_if.sv
// Word stream carrying 32-bit message data with valid/ready flow control and an end-of-message flag.
interface chacha20_keystream_xor_if;
  logic [31:0] data;
  logic        valid;
  logic        last;
  logic        ready;

  modport master (output data, valid, last, input ready);
  modport slave  (input data, valid, last, output ready);
endinterface

// File: rtl/chacha20_keystream_xor.sv
// Sequential wrapper around an external combinational ChaCha20 block function: builds the block
// input from key/nonce/counter, buffers one keystream block and XORs it onto a word stream.
module chacha20_keystream_xor #(
  parameter bit STOP_ON_WRAP = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [255:0]             key_i,
  input  logic [95:0]              nonce_i,
  input  logic [31:0]              initial_counter_i,
  output logic [511:0]             block_input_o,
  input  logic [511:0]             block_output_i,
  chacha20_keystream_xor_if.slave  din_i,
  chacha20_keystream_xor_if.master dout_o,
  output logic                     busy_o,
  output logic                     counter_wrapped_o
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLoad   = 2'd1;
  localparam logic [1:0] StStream = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [255:0]      key_q, key_d;
  logic [95:0]       nonce_q, nonce_d;
  logic [31:0]       ctr_q, ctr_d;
  logic [15:0][31:0] ks_q, ks_d;
  logic [3:0]        idx_q, idx_d;
  logic [31:0]       out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              wrapped_q, wrapped_d;
  logic              in_ready;
  logic              accept;

  assign block_input_o = {nonce_q, ctr_q, key_q,
                          32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

  assign in_ready = (state_q == StStream) && (!out_valid_q || dout_o.ready);
  assign accept   = din_i.valid && in_ready;

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    nonce_d     = nonce_q;
    ctr_d       = ctr_q;
    ks_d        = ks_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    wrapped_d   = wrapped_q;

    if (out_valid_q && dout_o.ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (start_i) begin
          key_d     = key_i;
          nonce_d   = nonce_i;
          ctr_d     = initial_counter_i;
          wrapped_d = 1'b0;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        // Once the counter has wrapped, refuse to reuse a counter value.
        if (STOP_ON_WRAP && wrapped_q) begin
          state_d = StIdle;
        end else begin
          ks_d    = block_output_i;
          idx_d   = 4'd0;
          ctr_d   = ctr_q + 32'd1;
          state_d = StStream;
          if (ctr_q == 32'hFFFF_FFFF) begin
            wrapped_d = 1'b1;
          end
        end
      end
      StStream: begin
        if (accept) begin
          out_data_d  = din_i.data ^ ks_q[idx_q];
          out_valid_d = 1'b1;
          out_last_d  = din_i.last;
          idx_d       = idx_q + 4'd1;
          if (din_i.last) begin
            state_d = StIdle;
          end else if (idx_q == 4'd15) begin
            state_d = StLoad;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      key_q       <= '0;
      nonce_q     <= '0;
      ctr_q       <= '0;
      ks_q        <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      wrapped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      nonce_q     <= nonce_d;
      ctr_q       <= ctr_d;
      ks_q        <= ks_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      wrapped_q   <= wrapped_d;
    end
  end

  assign din_i.ready       = in_ready;
  assign dout_o.data       = out_data_q;
  assign dout_o.valid      = out_valid_q;
  assign dout_o.last       = out_last_q;
  assign busy_o            = (state_q != StIdle);
  assign counter_wrapped_o = wrapped_q;

endmodule

// File: tb/tb_chacha20_keystream_xor.sv
// Bench: two DUTs (stop-on-wrap and silent-wrap) in lockstep, each fed by a behavioural block function.
module tb_chacha20_keystream_xor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  ictr;
  logic [511:0] bi1, bo1, bi2, bo2;
  logic         busy1, wr1, busy2, wr2;
  logic [31:0]  d_data;
  logic         d_valid, d_last, o_ready;

  chacha20_keystream_xor_if din1();
  chacha20_keystream_xor_if dout1();
  chacha20_keystream_xor_if din2();
  chacha20_keystream_xor_if dout2();

  assign din1.data   = d_data;
  assign din1.valid  = d_valid;
  assign din1.last   = d_last;
  assign din2.data   = d_data;
  assign din2.valid  = d_valid;
  assign din2.last   = d_last;
  assign dout1.ready = o_ready;
  assign dout2.ready = o_ready;

  function automatic logic [127:0] qr(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input logic [31:0] d);
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  // Reference ChaCha20 block function: 10 double rounds, then add the input state.
  function automatic logic [511:0] chacha_block(input logic [511:0] in);
    logic [31:0]  x[16];
    logic [127:0] r;
    logic [511:0] o;
    int ia, ib, ic, id;
    for (int i = 0; i < 16; i++) x[i] = in[32*i +: 32];
    for (int dr = 0; dr < 10; dr++) begin
      for (int q = 0; q < 8; q++) begin
        if (q < 4) begin
          ia = q; ib = q + 4; ic = q + 8; id = q + 12;
        end else begin
          ia = q - 4; ib = 4 + ((q - 3) % 4); ic = 8 + ((q - 2) % 4); id = 12 + ((q - 1) % 4);
        end
        r = qr(x[ia], x[ib], x[ic], x[id]);
        x[ia] = r[127:96]; x[ib] = r[95:64]; x[ic] = r[63:32]; x[id] = r[31:0];
      end
    end
    for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + in[32*i +: 32];
    return o;
  endfunction

  assign bo1 = chacha_block(bi1);
  assign bo2 = chacha_block(bi2);

  chacha20_keystream_xor #(.STOP_ON_WRAP(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .key_i(key), .nonce_i(nonce),
    .initial_counter_i(ictr), .block_input_o(bi1), .block_output_i(bo1),
    .din_i(din1), .dout_o(dout1), .busy_o(busy1), .counter_wrapped_o(wr1)
  );

  chacha20_keystream_xor #(.STOP_ON_WRAP(1'b0)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .key_i(key), .nonce_i(nonce),
    .initial_counter_i(ictr), .block_input_o(bi2), .block_output_i(bo2),
    .din_i(din2), .dout_o(dout2), .busy_o(busy2), .counter_wrapped_o(wr2)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] q1_data[$], q2_data[$], sent[$];
  logic        q1_last[$], q2_last[$];
  int          acc_cyc[$];
  bit          use_first = 1'b0;
  logic [31:0] first_word;

  // Output collectors, sampled mid-cycle so the observed handshake is the one taken at the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (dout1.valid && o_ready) begin q1_data.push_back(dout1.data); q1_last.push_back(dout1.last); end
      if (dout2.valid && o_ready) begin q2_data.push_back(dout2.data); q2_last.push_back(dout2.last); end
    end
  end

  // Expected keystream word: message word idx uses block counter c0+idx/16, word idx%16.
  function automatic logic [31:0] exp_ks(input logic [255:0] k, input logic [95:0] n,
                                         input logic [31:0] c0, input int idx);
    logic [31:0]  c;
    logic [511:0] blk;
    c   = c0 + 32'(idx / 16);
    blk = chacha_block({n, c, k, 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865});
    return blk[(idx % 16) * 32 +: 32];
  endfunction

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  task automatic clear_q();
    q1_data.delete(); q1_last.delete(); q2_data.delete(); q2_last.delete();
    sent.delete(); acc_cyc.delete();
  endtask

  task automatic do_start(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    key = k; nonce = n; ictr = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send_msg(input int n, input int last_idx, input int sel, output int n_acc);
    n_acc = 0;
    for (int k = 0; k < n; k++) begin
      bit acc;
      acc = 1'b0;
      d_data  = (k == 0 && use_first) ? first_word : $urandom;
      d_valid = 1'b1;
      d_last  = (k == last_idx);
      for (int t = 0; t < 40 && !acc; t++) begin
        @(negedge clk);
        if ((sel == 1) ? din1.ready : din2.ready) begin
          acc = 1'b1;
          sent.push_back(d_data);
          acc_cyc.push_back(cyc);
        end
        @(posedge clk); #1;
      end
      if (!acc) break;
      n_acc++;
    end
    d_valid = 1'b0;
    d_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; d_valid = 1'b0; d_last = 1'b0; d_data = '0; o_ready = 1'b1;
    key = '0; nonce = '0; ictr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if ({dout1.valid, dout1.last, din1.ready, busy1, wr1} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=00000", {dout1.valid, dout1.last, din1.ready, busy1, wr1});
    end
    total++; if (dout1.data !== 32'h0) begin
      bad++; $display("FAIL reset_data got=%h want=0", dout1.data);
    end
    total++; if (bi1[511:128] !== 384'h0) begin
      bad++; $display("FAIL reset_block_regs got=%h want=0", bi1[511:128]);
    end
    total++; if (bi1[127:0] !== 128'h6b206574_79622d32_3320646e_61707865) begin
      bad++; $display("FAIL reset_consts got=%h", bi1[127:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_known_vector();
    logic [255:0] k;
    int n_acc;
    for (int i = 0; i < 8; i++)
      k[32*i +: 32] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    clear_q();
    do_start(k, {32'h0, 32'h4a000000, 32'h0}, 32'd1);
    total++; if (bi1[415:384] !== 32'd1 || bi1[447:416] !== 32'h0 || bi1[479:448] !== 32'h4a000000) begin
      bad++; $display("FAIL kv_block_input got=%h want=4a000000_00000000_00000001", bi1[479:384]);
    end
    total++; if (bi1[159:128] !== 32'h03020100) begin
      bad++; $display("FAIL kv_key_word0 got=%h want=03020100", bi1[159:128]);
    end
    @(negedge clk);
    total++; if (din1.ready !== 1'b0) begin
      bad++; $display("FAIL kv_ready_load got=%b want=0", din1.ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (din1.ready !== 1'b1) begin
      bad++; $display("FAIL kv_ready_latency got=%b want=1", din1.ready);
    end
    @(posedge clk); #1;
    use_first = 1'b1; first_word = 32'h6964614c;
    send_msg(1, 0, 1, n_acc);
    use_first = 1'b0;
    drain();
    total++; if (q1_data.size() != 1 || q1_data[0] !== 32'h9a352e6e || q1_last[0] !== 1'b1) begin
      bad++; $display("FAIL kv_output got_n=%0d got=%h want=9a352e6e", q1_data.size(),
                      (q1_data.size() > 0) ? q1_data[0] : 32'hx);
    end
    total++; if (busy1 !== 1'b0) begin
      bad++; $display("FAIL kv_idle got=%b want=0", busy1);
    end
  endtask

  task automatic test_multi_block();
    logic [255:0] k = rand_key();
    logic [95:0]  n = {$urandom, $urandom, $urandom};
    logic [31:0]  c = 32'($urandom_range(0, 1000));
    int n_acc;
    clear_q();
    do_start(k, n, c);
    send_msg(20, 19, 1, n_acc);
    drain();
    total++; if (n_acc != 20 || q1_data.size() != 20) begin
      bad++; $display("FAIL mb_count got=%0d/%0d want=20", n_acc, q1_data.size());
    end
    for (int i = 0; i < 20 && i < q1_data.size(); i++) begin
      total++; if (q1_data[i] !== (sent[i] ^ exp_ks(k, n, c, i)) || q1_last[i] !== (i == 19)) begin
        bad++; $display("FAIL mb_word[%0d] got=%h/%b want=%h/%b", i, q1_data[i], q1_last[i],
                        sent[i] ^ exp_ks(k, n, c, i), i == 19);
      end
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      total++; if (acc_cyc[i] - acc_cyc[i-1] != ((i == 16) ? 2 : 1)) begin
        bad++; $display("FAIL mb_spacing[%0d] got=%0d want=%0d", i, acc_cyc[i] - acc_cyc[i-1],
                        (i == 16) ? 2 : 1);
      end
    end
    total++; if (busy1 !== 1'b0) begin
      bad++; $display("FAIL mb_idle got=%b want=0", busy1);
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] k = rand_key();
    logic [95:0]  n = {$urandom, $urandom, $urandom};
    logic [31:0]  c = 32'($urandom_range(0, 1000));
    int n_acc;
    clear_q();
    do_start(k, n, c);
    fork
      send_msg(12, 11, 1, n_acc);
      begin
        logic [31:0] held;
        repeat (6) @(posedge clk);
        #1 o_ready = 1'b0;
        @(negedge clk);
        held = dout1.data;
        for (int i = 0; i < 5; i++) begin
          total++; if (din1.ready !== 1'b0 || dout1.valid !== 1'b1 || dout1.data !== held) begin
            bad++; $display("FAIL bp_hold[%0d] got=%b/%b/%h want=0/1/%h", i, din1.ready,
                            dout1.valid, dout1.data, held);
          end
          if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1 o_ready = 1'b1;
      end
    join
    drain();
    total++; if (n_acc != 12 || q1_data.size() != 12) begin
      bad++; $display("FAIL bp_count got=%0d/%0d want=12", n_acc, q1_data.size());
    end
    for (int i = 0; i < 12 && i < q1_data.size(); i++) begin
      total++; if (q1_data[i] !== (sent[i] ^ exp_ks(k, n, c, i))) begin
        bad++; $display("FAIL bp_word[%0d] got=%h want=%h", i, q1_data[i], sent[i] ^ exp_ks(k, n, c, i));
      end
    end
  endtask

  task automatic test_early_last();
    logic [255:0] k = rand_key();
    logic [95:0]  n = {$urandom, $urandom, $urandom};
    int n_acc;
    clear_q();
    do_start(k, n, 32'd3);
    send_msg(4, 3, 1, n_acc);
    drain();
    total++; if (q1_data.size() != 4 || busy1 !== 1'b0 || din1.ready !== 1'b0 || q1_last[3] !== 1'b1) begin
      bad++; $display("FAIL el_end got_n=%0d busy=%b ready=%b want=4/0/0", q1_data.size(), busy1, din1.ready);
    end
    clear_q();
    do_start(k, n, 32'd7);
    total++; if (bi1[415:384] !== 32'd7) begin
      bad++; $display("FAIL el_counter got=%h want=7", bi1[415:384]);
    end
    send_msg(1, 0, 1, n_acc);
    drain();
    total++; if (q1_data.size() != 1 || q1_data[0] !== (sent[0] ^ exp_ks(k, n, 32'd7, 0))) begin
      bad++; $display("FAIL el_restart got_n=%0d want=1", q1_data.size());
    end
  endtask

  task automatic test_wrap();
    logic [255:0] k = rand_key();
    logic [95:0]  n = {$urandom, $urandom, $urandom};
    int n_acc;
    clear_q();
    do_start(k, n, 32'hFFFF_FFFF);
    send_msg(17, 16, 2, n_acc);
    drain();
    total++; if (q1_data.size() != 16 || wr1 !== 1'b1 || busy1 !== 1'b0) begin
      bad++; $display("FAIL wrap_stop got_n=%0d wr=%b busy=%b want=16/1/0", q1_data.size(), wr1, busy1);
    end
    total++; if (q2_data.size() != 17 || wr2 !== 1'b1 || busy2 !== 1'b0) begin
      bad++; $display("FAIL wrap_silent got_n=%0d wr=%b busy=%b want=17/1/0", q2_data.size(), wr2, busy2);
    end
    for (int i = 0; i < 16 && i < q1_data.size(); i++) begin
      total++; if (q1_data[i] !== (sent[i] ^ exp_ks(k, n, 32'hFFFF_FFFF, i)) || q1_last[i] !== 1'b0) begin
        bad++; $display("FAIL wrap1_word[%0d] got=%h want=%h", i, q1_data[i],
                        sent[i] ^ exp_ks(k, n, 32'hFFFF_FFFF, i));
      end
    end
    for (int i = 0; i < 17 && i < q2_data.size(); i++) begin
      total++; if (q2_data[i] !== (sent[i] ^ exp_ks(k, n, 32'hFFFF_FFFF, i))) begin
        bad++; $display("FAIL wrap2_word[%0d] got=%h want=%h", i, q2_data[i],
                        sent[i] ^ exp_ks(k, n, 32'hFFFF_FFFF, i));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] k = rand_key();
    logic [95:0]  n = {$urandom, $urandom, $urandom};
    logic [31:0]  c = 32'($urandom_range(0, 1000));
    int n_acc;
    clear_q();
    do_start(rand_key(), {$urandom, $urandom, $urandom}, 32'd5);
    o_ready = 1'b0;
    send_msg(1, -1, 1, n_acc);
    @(negedge clk);
    total++; if (dout1.valid !== 1'b1 || busy1 !== 1'b1) begin
      bad++; $display("FAIL rm_pending got=%b/%b want=1/1", dout1.valid, busy1);
    end
    #2 rst = 1'b1;
    #1;
    total++; if ({dout1.valid, dout1.last, din1.ready, busy1, wr1} !== 5'b0 || dout1.data !== 32'h0
                 || bi1[415:384] !== 32'h0) begin
      bad++; $display("FAIL rm_async got=%b/%h/%h want=0", {dout1.valid, dout1.last, din1.ready, busy1, wr1},
                      dout1.data, bi1[415:384]);
    end
    @(posedge clk); #1 rst = 1'b0; o_ready = 1'b1;
    clear_q();
    do_start(k, n, c);
    send_msg(3, 2, 1, n_acc);
    drain();
    total++; if (q1_data.size() != 3 || busy1 !== 1'b0 || wr1 !== 1'b0) begin
      bad++; $display("FAIL rm_count got_n=%0d want=3", q1_data.size());
    end
    for (int i = 0; i < 3 && i < q1_data.size(); i++) begin
      total++; if (q1_data[i] !== (sent[i] ^ exp_ks(k, n, c, i))) begin
        bad++; $display("FAIL rm_word[%0d] got=%h want=%h", i, q1_data[i], sent[i] ^ exp_ks(k, n, c, i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_multi_block();
    test_backpressure();
    test_early_last();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
